phy_rx_fifo: RTL and testbench

//  Receive-side buffer directly downstream of the phy block. Captures each word that phy

---
 rtl/phy_rx_fifo_pkg.sv | 19 +
 rtl/phy_rx_fifo_if.sv | 33 +++
 rtl/mem_2p.sv | 26 ++
 rtl/phy_rx_fifo.sv | 80 ++++++++
 tb/tb_phy_rx_fifo.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/phy_rx_fifo_pkg.sv
// Shared widths and helpers for the phy receive FIFO, so phy and FIFO agree on word size and depth.
package phy_rx_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 3;

    // Encoding is {push_accepted, pop_accepted}, so the pair casts directly.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/phy_rx_fifo_if.sv
// Push/pop/status bundle between phy, the receive FIFO and the link-layer consumer.
interface phy_rx_fifo_if
    import phy_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] data_final;
    logic                  valid_final;
    logic                  pop;
    logic [ADDR_WIDTH:0]   umbral_alto;
    logic [ADDR_WIDTH:0]   umbral_bajo;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  error_overflow;

    modport master (
        output data_final, valid_final, pop, umbral_alto, umbral_bajo,
        input  data_out, valid_out, count, fifo_empty, fifo_full,
               almost_empty, almost_full, error_overflow
    );

    modport slave (
        input  data_final, valid_final, pop, umbral_alto, umbral_bajo,
        output data_out, valid_out, count, fifo_empty, fifo_full,
               almost_empty, almost_full, error_overflow
    );
endinterface

// File: rtl/mem_2p.sv
// DEPTH x DATA_WIDTH register file: one synchronous write port, one synchronous read port.
module mem_2p
    import phy_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto plain flops/RAM; the owner tracks which words are valid.
    // A read and write to the same address in one cycle returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/phy_rx_fifo.sv
// Receive buffer behind phy: pointers, occupancy, threshold flags and sticky overflow around mem_2p.
module phy_rx_fifo
    import phy_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input logic         clk_f,
    input logic         reset,
    phy_rx_fifo_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  valid_q;
    logic                  overflow_q;
    logic                  rd_loaded;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  push_acc;
    logic                  pop_acc;
    fifo_op_e              op;

    // NOTE: every combinational output gets a value before any condition, so no latch is inferred.
    always_comb begin
        pop_acc  = 1'b0;
        push_acc = 1'b0;
        if (bus.pop && count_q != '0) pop_acc = 1'b1;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the word.
        if (bus.valid_final && (count_q != DEPTH || pop_acc)) push_acc = 1'b1;
        op = fifo_op_e'({push_acc, pop_acc});
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            rd_loaded  <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            case (op)
                OP_PUSH: count_q <= count_q + 1'b1;
                OP_POP:  count_q <= count_q - 1'b1;
                default: ;
            endcase
            valid_q <= pop_acc;
            if (pop_acc) rd_loaded <= 1'b1;
            if (bus.valid_final && !push_acc) overflow_q <= 1'b1;
        end
    end

    mem_2p #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk_f),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_final),
        .re    (pop_acc),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // The read register is not reset; until the first pop after reset data_out reads as zero.
    assign bus.data_out       = rd_loaded ? rdata : '0;
    assign bus.valid_out      = valid_q;
    assign bus.count          = count_q;
    assign bus.fifo_empty     = (count_q == '0);
    assign bus.fifo_full      = (count_q == DEPTH);
    assign bus.almost_empty   = (count_q <= bus.umbral_bajo);
    assign bus.almost_full    = (count_q >= bus.umbral_alto);
    assign bus.error_overflow = overflow_q;
endmodule

// File: tb/tb_phy_rx_fifo.sv
// Self-checking bench for phy_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_phy_rx_fifo;
    import phy_rx_fifo_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk_f = 1'b0;
    logic reset;
    always #5 clk_f = ~clk_f;

    phy_rx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    phy_rx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_f (clk_f),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of stored words plus the last popped word.
    logic [DW-1:0] mdl_q [$];
    logic [DW-1:0] mdl_dout;
    logic          mdl_valid;
    logic          mdl_ovf;
    int            thr_hi;
    int            thr_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_dout  = '0;
        mdl_valid = 1'b0;
        mdl_ovf   = 1'b0;
    endtask

    task automatic set_thr(input int hi, input int lo);
        thr_hi = hi;
        thr_lo = lo;
        bus.umbral_alto = (AW+1)'(hi);
        bus.umbral_bajo = (AW+1)'(lo);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mdl_q.size();
        check({tag, ".count"},    64'(bus.count),          64'(n));
        check({tag, ".empty"},    64'(bus.fifo_empty),     64'(n == 0));
        check({tag, ".full"},     64'(bus.fifo_full),      64'(n == DEPTH));
        check({tag, ".alm_full"}, 64'(bus.almost_full),    64'(n >= thr_hi));
        check({tag, ".alm_empty"},64'(bus.almost_empty),   64'(n <= thr_lo));
        check({tag, ".valid"},    64'(bus.valid_out),      64'(mdl_valid));
        check({tag, ".data"},     64'(bus.data_out),       64'(mdl_dout));
        check({tag, ".ovf"},      64'(bus.error_overflow), 64'(mdl_ovf));
    endtask

    // One clock: drive inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input logic vf, input logic [DW-1:0] d, input logic p, input string tag);
        bit pop_ok, push_ok;
        bus.valid_final = vf;
        bus.data_final  = d;
        bus.pop         = p;
        @(posedge clk_f);
        pop_ok  = p && (mdl_q.size() > 0);
        push_ok = vf && (mdl_q.size() < DEPTH || pop_ok);
        mdl_valid = pop_ok;
        if (pop_ok) mdl_dout = mdl_q.pop_front();
        if (push_ok) mdl_q.push_back(d);
        else if (vf) mdl_ovf = 1'b1;
        #1;
        check_all(tag);
        @(negedge clk_f);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk_f);
        reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w;

        // Reset held with random inputs, including a random threshold pair.
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            bus.valid_final = 1'($urandom);
            bus.data_final  = $urandom;
            bus.pop         = 1'($urandom);
            set_thr($urandom_range(0, 15), $urandom_range(0, 15));
            @(negedge clk_f);
            check_all("reset");
        end
        set_thr(0, 0);
        #1;
        check_all("reset_thr0");
        reset = 1'b0;
        set_thr(6, 2);

        // Fill then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hA000_0000 + DW'(i), 1'b0, "fill");
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "drain");

        // Overflow: dropped word never appears, flag is sticky across pops.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hB000_0000 + DW'(i), 1'b0, "ovf_fill");
        step(1'b1, 32'hDEAD_BEEF, 1'b0, "ovf_push");
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, "ovf_drain");
            check("ovf_no_deadbeef", 64'(bus.valid_out && bus.data_out == 32'hDEAD_BEEF), 64'd0);
        end
        step(1'b0, '0, 1'b1, "pop_empty");
        pulse_reset("ovf_clear");

        // Push+pop while full: count stays at DEPTH, no overflow, new word comes out last.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'hC000_0000 + DW'(i), 1'b0, "full_fill");
        step(1'b1, 32'hC0FF_EE00, 1'b1, "full_both");
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, "full_drain");

        // Single push/pop pairs so both pointers wrap twice.
        for (int i = 0; i < 20; i++) begin
            w = $urandom;
            step(1'b1, w, 1'b0, "wrap_push");
            step(1'b0, '0, 1'b1, "wrap_pop");
        end
        step(1'b1, 32'h1234_5678, 1'b1, "empty_both");
        step(1'b0, '0, 1'b1, "empty_both_pop");

        // Thresholds 6/2: fill to 6, drop to 5, then reset with a pop in flight.
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, "thr_fill");
        step(1'b0, '0, 1'b1, "thr_pop");
        bus.valid_final = 1'b0;
        bus.pop         = 1'b1;
        @(posedge clk_f);
        #2;
        pulse_reset("mid_reset");

        // Random traffic with thresholds changing on the fly.
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) set_thr($urandom_range(0, 15), $urandom_range(0, 15));
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
